// File: rtl/sn76489_cmd_decoder.sv
// SN76489 command decoder: counts bit strobes, captures each finished byte and applies it to the register file.
// Optional SN76489_FRAME_TIMEOUT_EN discards a partial byte after TIMEOUT_CYCLES idle cycles.
module sn76489_cmd_decoder #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SHIFT_EN,
  input  logic [7:0] BYTE_IN,
  output logic [9:0] TONE0,
  output logic [9:0] TONE1,
  output logic [9:0] TONE2,
  output logic [3:0] ATTEN0,
  output logic [3:0] ATTEN1,
  output logic [3:0] ATTEN2,
  output logic [3:0] ATTEN3,
  output logic [2:0] NOISE_CTRL,
  output logic       NOISE_RESET,
  output logic       WR_STROBE,
  output logic [2:0] WR_ADDR
);

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       pending_q, pending_d;
  logic       cap_valid_q, cap_valid_d;
  logic [7:0] cap_byte_q, cap_byte_d;
  logic [2:0] latch_q, latch_d;
  logic [9:0] tone_q [3];
  logic [9:0] tone_d [3];
  logic [3:0] atten_q [4];
  logic [3:0] atten_d [4];
  logic [2:0] noise_ctrl_q, noise_ctrl_d;
  logic       noise_reset_q, noise_reset_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [2:0] wr_addr_q, wr_addr_d;

  logic [2:0] target;
  logic [1:0] ch;
  logic       is_atten;

`ifdef SN76489_FRAME_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] idle_q, idle_d;
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
`endif

  // Byte framing: the byte is sampled in the cycle after the 8th strobe, once upstream has shifted it in.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned and no latch is inferred.
    bit_cnt_d   = bit_cnt_q;
    pending_d   = 1'b0;
    cap_valid_d = pending_q;
    cap_byte_d  = pending_q ? BYTE_IN : cap_byte_q;
    if (SHIFT_EN) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) pending_d = 1'b1;
    end
`ifdef SN76489_FRAME_TIMEOUT_EN
    idle_d = 16'd0;
    if (!SHIFT_EN && bit_cnt_q != 3'd0) begin
      if (idle_q + 16'd1 == TIMEOUT_LIMIT) begin
        bit_cnt_d = 3'd0;
      end else begin
        idle_d = idle_q + 16'd1;
      end
    end
`endif
  end

  // Register file update from the captured byte; a data byte reuses the last latched register.
  always_comb begin
    target   = cap_byte_q[7] ? cap_byte_q[6:4] : latch_q;
    ch       = target[2:1];
    is_atten = target[0];

    latch_d       = latch_q;
    tone_d        = tone_q;
    atten_d       = atten_q;
    noise_ctrl_d  = noise_ctrl_q;
    noise_reset_d = 1'b0;
    wr_strobe_d   = 1'b0;
    wr_addr_d     = wr_addr_q;

    if (cap_valid_q) begin
      wr_strobe_d = 1'b1;
      wr_addr_d   = target;
      if (cap_byte_q[7]) latch_d = cap_byte_q[6:4];
      if (is_atten) begin
        atten_d[ch] = cap_byte_q[3:0];
      end else if (ch == 2'd3) begin
        noise_ctrl_d  = cap_byte_q[2:0];
        noise_reset_d = 1'b1;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (ch == 2'(i)) begin
            if (cap_byte_q[7]) tone_d[i][3:0] = cap_byte_q[3:0];
            else               tone_d[i][9:4] = cap_byte_q[5:0];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt_q     <= 3'd0;
      pending_q     <= 1'b0;
      cap_valid_q   <= 1'b0;
      latch_q       <= 3'b000;
      // NOTE: the register file is visible on the ports, so every entry gets a defined reset value.
      for (int i = 0; i < 3; i++) tone_q[i] <= 10'd0;
      for (int i = 0; i < 4; i++) atten_q[i] <= 4'hF;
      noise_ctrl_q  <= 3'd0;
      noise_reset_q <= 1'b0;
      wr_strobe_q   <= 1'b0;
      wr_addr_q     <= 3'd0;
`ifdef SN76489_FRAME_TIMEOUT_EN
      idle_q        <= 16'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
      bit_cnt_q     <= bit_cnt_d;
      pending_q     <= pending_d;
      cap_valid_q   <= cap_valid_d;
      latch_q       <= latch_d;
      tone_q        <= tone_d;
      atten_q       <= atten_d;
      noise_ctrl_q  <= noise_ctrl_d;
      noise_reset_q <= noise_reset_d;
      wr_strobe_q   <= wr_strobe_d;
      wr_addr_q     <= wr_addr_d;
`ifdef SN76489_FRAME_TIMEOUT_EN
      idle_q        <= idle_d;
`endif
    end
  end

  // Captured byte is qualified by cap_valid_q, so it needs no reset.
  always_ff @(posedge CLK) begin
    cap_byte_q <= cap_byte_d;
  end

  assign TONE0       = tone_q[0];
  assign TONE1       = tone_q[1];
  assign TONE2       = tone_q[2];
  assign ATTEN0      = atten_q[0];
  assign ATTEN1      = atten_q[1];
  assign ATTEN2      = atten_q[2];
  assign ATTEN3      = atten_q[3];
  assign NOISE_CTRL  = noise_ctrl_q;
  assign NOISE_RESET = noise_reset_q;
  assign WR_STROBE   = wr_strobe_q;
  assign WR_ADDR     = wr_addr_q;

endmodule

// File: tb/tb_sn76489_cmd_decoder.sv
// Scoreboard bench for sn76489_cmd_decoder: a register-file model queues the expected state per command byte,
// and a monitor compares it against the DUT on every WR_STROBE.
module tb_sn76489_cmd_decoder;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SHIFT_EN = 1'b0;
  logic       bit_in = 1'b0;
  logic [7:0] sr = 8'd0;
  logic [7:0] BYTE_IN;
  logic [9:0] TONE0, TONE1, TONE2;
  logic [3:0] ATTEN0, ATTEN1, ATTEN2, ATTEN3;
  logic [2:0] NOISE_CTRL;
  logic       NOISE_RESET;
  logic       WR_STROBE;
  logic [2:0] WR_ADDR;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0]  addr;
    logic        nr;
    logic [29:0] tones;
    logic [15:0] attens;
    logic [2:0]  noise;
  } exp_t;

  exp_t exp_q[$];

  logic [9:0] m_tone [3];
  logic [3:0] m_atten [4];
  logic [2:0] m_noise;
  logic [2:0] m_latch;

  always #5 CLK = ~CLK;

  // Upstream serial shift register: LSB-first bits enter at the top and settle at bit 0.
  always @(posedge CLK) if (SHIFT_EN) sr <= {bit_in, sr[7:1]};
  assign BYTE_IN = sr;

  sn76489_cmd_decoder #(.TIMEOUT_CYCLES(10)) dut (
    .CLK(CLK), .RST(RST), .SHIFT_EN(SHIFT_EN), .BYTE_IN(BYTE_IN),
    .TONE0(TONE0), .TONE1(TONE1), .TONE2(TONE2),
    .ATTEN0(ATTEN0), .ATTEN1(ATTEN1), .ATTEN2(ATTEN2), .ATTEN3(ATTEN3),
    .NOISE_CTRL(NOISE_CTRL), .NOISE_RESET(NOISE_RESET),
    .WR_STROBE(WR_STROBE), .WR_ADDR(WR_ADDR)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_tone[i] = 10'd0;
    for (int i = 0; i < 4; i++) m_atten[i] = 4'hF;
    m_noise = 3'd0;
    m_latch = 3'd0;
  endtask

  // Applies one command byte to the model register file and queues the resulting state.
  task automatic model_apply(input logic [7:0] b);
    exp_t e;
    int   chn;
    logic is_vol;
    if (b[7]) m_latch = b[6:4];
    chn    = int'(m_latch[2:1]);
    is_vol = m_latch[0];
    e.nr   = 1'b0;
    if (is_vol)        m_atten[chn] = b[3:0];
    else if (chn == 3) begin m_noise = b[2:0]; e.nr = 1'b1; end
    else if (b[7])     m_tone[chn] = (m_tone[chn] & 10'h3F0) | 10'(b[3:0]);
    else               m_tone[chn] = (m_tone[chn] & 10'h00F) | (10'(b[5:0]) << 4);
    e.addr   = m_latch;
    e.tones  = {m_tone[2], m_tone[1], m_tone[0]};
    e.attens = {m_atten[3], m_atten[2], m_atten[1], m_atten[0]};
    e.noise  = m_noise;
    exp_q.push_back(e);
  endtask

  task automatic shift_bits(input logic [7:0] b, input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      SHIFT_EN = 1'b1;
      bit_in   = b[i];
      repeat ($urandom_range(0, gap_max)) begin
        @(negedge CLK);
        SHIFT_EN = 1'b0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    model_apply(b);
    shift_bits(b, 8, gap_max);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      SHIFT_EN = 1'b0;
    end
  endtask

  task automatic drain();
    int budget = 40;
    idle(1);
    while (exp_q.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    check("drain_pending_writes", 32'(exp_q.size()), 32'd0);
    idle(2);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    SHIFT_EN = 1'b0;
    idle(2);
    RST = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  // Monitor: pops one expectation per WR_STROBE and checks pulse widths.
  initial begin
    logic prev_strobe;
    exp_t e;
    prev_strobe = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev_strobe = 1'b0;
      end else begin
        if (prev_strobe) begin
          check("wr_strobe_width", 32'(WR_STROBE), 32'd0);
          check("noise_reset_width", 32'(NOISE_RESET), 32'd0);
        end
        if (WR_STROBE) begin
          check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(WR_ADDR), 32'(e.addr));
            check("noise_reset", 32'(NOISE_RESET), 32'(e.nr));
            check("tones", 32'({TONE2, TONE1, TONE0}), 32'(e.tones));
            check("attens", 32'({ATTEN3, ATTEN2, ATTEN1, ATTEN0}), 32'(e.attens));
            check("noise_ctrl", 32'(NOISE_CTRL), 32'(e.noise));
          end
        end
        prev_strobe = WR_STROBE;
      end
    end
  end

  initial begin
    logic [7:0] b;
    model_reset();
    do_reset();
    idle(1);
    check("reset_tones", 32'({TONE2, TONE1, TONE0}), 32'd0);
    check("reset_attens", 32'({ATTEN3, ATTEN2, ATTEN1, ATTEN0}), 32'h0000_FFFF);
    check("reset_noise_ctrl", 32'(NOISE_CTRL), 32'd0);
    check("reset_pulses", 32'({WR_STROBE, NOISE_RESET}), 32'd0);

    // Data byte straight after reset targets tone0 high bits.
    send_byte(8'h2A, 1);
    drain();
    check("data_after_reset_tone0", 32'(TONE0), 32'h2A0);

    send_byte(8'h8E, 2);
    send_byte(8'h0F, 2);
    drain();
    check("tone0_two_byte", 32'(TONE0), 32'h0FE);

    send_byte(8'h9A, 1);
    send_byte(8'hFF, 1);
    send_byte(8'h03, 1);
    drain();
    check("atten0", 32'(ATTEN0), 32'hA);
    check("atten3_data", 32'(ATTEN3), 32'h3);

    send_byte(8'hE5, 0);
    send_byte(8'h06, 0);
    drain();
    check("noise_ctrl_data", 32'(NOISE_CTRL), 32'h6);

    // Back-to-back: SHIFT_EN held high for 16 cycles, including the pending cycle.
    send_byte(8'hC7, 0);
    send_byte(8'h3F, 0);
    drain();
    check("tone2_back_to_back", 32'(TONE2), 32'h3F7);

    // Reset mid-byte, then a full byte.
    shift_bits(8'h55, 5, 1);
    do_reset();
    send_byte(8'h9A, 1);
    drain();
    check("atten0_after_midbyte_reset", 32'(ATTEN0), 32'hA);

`ifdef SN76489_FRAME_TIMEOUT_EN
    shift_bits(8'hFF, 3, 0);
    idle(11);
    send_byte(8'h9A, 1);
    drain();
    check("atten0_after_timeout", 32'(ATTEN0), 32'hA);
`endif

    // Random command stream, mixing gaps and back-to-back bytes.
    for (int n = 0; n < 120; n++) begin
      b = 8'($urandom_range(0, 255));
      send_byte(b, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sn76489_cmd_decoder.md
Name: sn76489_cmd_decoder

Overview:
- Consumer stage directly downstream of the serial byte shift register in the TI_SN76489 path.
- Counts bit strobes and captures each completed 8-bit byte from the shift register's parallel output.
- Decodes SN76489 latch/data command bytes into the chip register file: 3 tone periods, 4 attenuators, noise control.
- Drives the tone, noise and attenuation generators.

Parameters:
- TIMEOUT_CYCLES, 255: idle cycles allowed mid-byte before the bit counter is abandoned. Used only with the optional feature. Range 1..65535.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous reset, active-high.
- SHIFT_EN  in  1  bit strobe; high in the same cycle the upstream shift register shifts in one bit. Bits arrive LSB first.
- BYTE_IN  in  8  parallel contents of the upstream shift register.
- TONE0, TONE1, TONE2  out  10 each  tone period registers.
- ATTEN0, ATTEN1, ATTEN2, ATTEN3  out  4 each  attenuation registers; ATTEN3 is the noise channel.
- NOISE_CTRL  out  3  bit2 = FB (white/periodic), bits1:0 = shift rate.
- NOISE_RESET  out  1  one-cycle pulse on any noise register write; resets the noise LFSR.
- WR_STROBE  out  1  one-cycle pulse on every register update.
- WR_ADDR  out  3  register written while WR_STROBE is high: {channel[1:0], type}.

Behaviour:
Reset, applied synchronously and able to override everything including mid-byte and a pending decode:
- TONEx = 0, ATTENx = 4'hF (silent), NOISE_CTRL = 0.
- NOISE_RESET = 0, WR_STROBE = 0.
- Latched register = 3'b000 (tone0).
- Bit counter = 0, pending flag = 0.

Byte capture:
- 3-bit bit counter increments on each SHIFT_EN.
- On the SHIFT_EN that takes the counter from 7 to 0, the pending flag is set.
- In the next cycle (pending = 1) BYTE_IN holds the complete byte: decode it, clear pending.
- SHIFT_EN during the pending cycle counts toward the next byte. BYTE_IN has not yet changed in that cycle, so no byte is lost.
- Latency: registers update on the edge 2 cycles after the 8th SHIFT_EN edge. WR_STROBE, WR_ADDR and NOISE_RESET are valid in the cycle following that update.

Decode when BYTE_IN[7] = 1 (latch byte):
- Latched register <= BYTE_IN[6:4] (channel = [6:5], type = [4]).
- Type 1: ATTENch <= BYTE_IN[3:0].
- Type 0, channel 0..2: TONEch[3:0] <= BYTE_IN[3:0]; TONEch[9:4] unchanged.
- Type 0, channel 3: NOISE_CTRL <= BYTE_IN[2:0]; pulse NOISE_RESET.

Decode when BYTE_IN[7] = 0 (data byte), targeting the latched register:
- Tone: TONEch[9:4] <= BYTE_IN[5:0].
- Attenuation: ATTENch <= BYTE_IN[3:0].
- Noise: NOISE_CTRL <= BYTE_IN[2:0]; pulse NOISE_RESET.
- BYTE_IN[6] is ignored.

Strobes:
- Every decode pulses WR_STROBE with WR_ADDR = target register.
- Two decodes are at least 8 SHIFT_EN strobes apart, so strobe pulses never merge.

Boundary conditions:
- Data byte with no prior latch byte after reset writes tone0[9:4].
- Consecutive data bytes keep writing the same latched register.

Optional Feature:
- Macro: SN76489_FRAME_TIMEOUT_EN.
- Defined: a 16-bit idle counter runs while bit counter != 0 and SHIFT_EN = 0, and clears on any SHIFT_EN. When it reaches TIMEOUT_CYCLES, the bit counter and idle counter reset to 0; the partial byte is discarded and no decode occurs. The pending flag is not affected.
- Not defined: no idle counter; the bit counter holds indefinitely between strobes.

Test Plan:
1. Reset: assert RST 2 cycles -> TONE0..2 = 0, ATTEN0..3 = 4'hF, NOISE_CTRL = 0, all pulses low.
2. Tone write: shift 0x8E, then 0x0F, LSB first -> after byte 1, TONE0 = 10'h00E with WR_STROBE, WR_ADDR = 0; after byte 2, TONE0 = 10'h0FE.
3. Attenuation and channel 3: shift 0x9A -> ATTEN0 = 4'hA, WR_ADDR = 1. Shift 0xFF -> ATTEN3 = 4'hF, WR_ADDR = 7. Then data byte 0x03 -> ATTEN3 = 4'h3.
4. Noise: shift 0xE5 -> NOISE_CTRL = 3'b101, NOISE_RESET high exactly 1 cycle. Data byte 0x06 -> NOISE_CTRL = 3'b110, second NOISE_RESET pulse.
5. Back-to-back bytes: SHIFT_EN high continuously for 16 cycles with 0xC7 then 0x3F -> TONE2 = 10'h3F7. Both decodes occur and no bit is lost despite SHIFT_EN during the pending cycle.
6. Reset and timeout: RST after 5 bits, then a full 0x9A -> ATTEN0 = 4'hA. With SN76489_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES = 10: 3 bits, 11 idle cycles, then 0x9A -> ATTEN0 = 4'hA, no stray decode.
